// File: rtl/quad_latch_writer_if.sv
// Producer-side valid/ready channel carrying 4-bit words into quad_latch_writer.
interface quad_latch_writer_if;
  logic [3:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;

  modport master (output wr_data, output wr_valid, input wr_ready);
  modport slave (input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/quad_latch_writer.sv
// Write sequencer for a quad D latch: FIFO-buffered nibbles strobed with setup/gate/hold windows.
// Optional macro QLW_COALESCE_EN discards popped words equal to the last committed value.
module quad_latch_writer #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned GATE_CYC  = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  quad_latch_writer_if.slave     wr,
  output logic [3:0]             d,
  output logic                   g,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic [3:0]             shadow
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned MaxCyc =
      (SETUP_CYC > GATE_CYC) ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                             : ((GATE_CYC > HOLD_CYC) ? GATE_CYC : HOLD_CYC);
  localparam int unsigned CW = $clog2(MaxCyc + 1);

  localparam logic [AW:0]   DepthC = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] SetupC = CW'(SETUP_CYC);
  localparam logic [CW-1:0] GateC  = CW'(GATE_CYC);
  localparam logic [CW-1:0] HoldC  = CW'(HOLD_CYC);
  localparam logic [CW-1:0] OneC   = CW'(1);

  typedef enum logic [1:0] {StIdle, StSetup, StOpen, StHold} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [3:0]    d_q, d_d;
  logic [3:0]    shadow_q, shadow_d;
  logic          g_q, g_d;
  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          push, pop, load, strobe;
  logic [3:0]    head;
`ifdef QLW_COALESCE_EN
  logic          sv_q, sv_d;
`endif

  assign wr.wr_ready = (count_q < DepthC);
  assign push        = wr.wr_valid && wr.wr_ready;
  assign head        = mem_q[rptr_q];

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    d_d      = d_q;
    g_d      = g_q;
    shadow_d = shadow_q;
    load     = 1'b0;
    strobe   = 1'b0;
`ifdef QLW_COALESCE_EN
    sv_d     = sv_q;
`endif
    unique case (state_q)
      StIdle: load = (count_q != '0);
      StSetup: begin
        if (cyc_q == OneC) begin
          g_d     = 1'b1;
          state_d = StOpen;
          cyc_d   = GateC;
        end else begin
          cyc_d = cyc_q - 1'b1;
        end
      end
      StOpen: begin
        if (cyc_q == OneC) begin
          g_d     = 1'b0;
          state_d = StHold;
          cyc_d   = HoldC;
        end else begin
          cyc_d = cyc_q - 1'b1;
        end
      end
      StHold: begin
        if (cyc_q == OneC) begin
          shadow_d = d_q;
`ifdef QLW_COALESCE_EN
          sv_d     = 1'b1;
`endif
          state_d  = StIdle;
          load     = (count_q != '0);
        end else begin
          cyc_d = cyc_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    pop = load;
    if (load) begin
      strobe = 1'b1;
`ifdef QLW_COALESCE_EN
      // Compare against the value committed on this same edge when leaving HOLD.
      if (sv_d && (head == shadow_d)) strobe = 1'b0;
`endif
      if (strobe) begin
        d_d     = head;
        state_d = StSetup;
        cyc_d   = SetupC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cyc_q    <= '0;
      d_q      <= '0;
      g_q      <= 1'b0;
      shadow_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
`ifdef QLW_COALESCE_EN
      sv_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      d_q      <= d_d;
      g_q      <= g_d;
      shadow_q <= shadow_d;
`ifdef QLW_COALESCE_EN
      sv_q     <= sv_d;
`endif
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wptr_q] <= wr.wr_data;
  end

  assign d      = d_q;
  assign g      = g_q;
  assign shadow = shadow_q;
  assign count  = count_q;
  assign busy   = (state_q != StIdle) || (count_q != '0);
endmodule

// File: tb/tb_quad_latch_writer.sv
// Bench for quad_latch_writer: two instances (default timing and 3/3/3) against a schedule model.
module tb_quad_latch_writer;
  localparam int unsigned DEPTH = 4;
  localparam int S0 = 1, G0 = 2, H0 = 1;
  localparam int S1 = 3, G1 = 3, H1 = 3;
`ifdef QLW_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data;
  logic       vld;
  bit         chk_en;
  int         total, bad;

  always #5 clk = ~clk;

  quad_latch_writer_if if_a ();
  quad_latch_writer_if if_b ();
  assign if_a.wr_data  = data;
  assign if_a.wr_valid = vld;
  assign if_b.wr_data  = data;
  assign if_b.wr_valid = vld;

  logic [3:0] od [2];
  logic [3:0] osh [2];
  logic       og [2];
  logic       obusy [2];
  logic       ordy [2];
  logic [2:0] ocnt [2];
  assign ordy[0] = if_a.wr_ready;
  assign ordy[1] = if_b.wr_ready;

  quad_latch_writer #(.DEPTH(DEPTH), .SETUP_CYC(S0), .GATE_CYC(G0), .HOLD_CYC(H0)) u_dut0 (
    .clk(clk), .rst(rst), .wr(if_a), .d(od[0]), .g(og[0]), .busy(obusy[0]), .count(ocnt[0]),
    .shadow(osh[0])
  );
  quad_latch_writer #(.DEPTH(DEPTH), .SETUP_CYC(S1), .GATE_CYC(G1), .HOLD_CYC(H1)) u_dut1 (
    .clk(clk), .rst(rst), .wr(if_b), .d(od[1]), .g(og[1]), .busy(obusy[1]), .count(ocnt[1]),
    .shadow(osh[1])
  );

  // Model: FIFO as a ring of words; a strobe is the pop edge plus an elapsed-cycle count k.
  logic [3:0] mbuf [2][16];
  int         mhead [2], msize [2], mk [2];
  bit         mact [2], msv [2];
  logic [3:0] md [2], msh [2];
  bit         m_push, m_may;
  logic [3:0] m_w;

  int         gp [2], rn [2], dchg [2], peak1;
  logic [3:0] rl [2][64];
  logic       gprev [2];
  logic [3:0] dprev [2];

  logic [3:0] seq2 [4] = '{4'hA, 4'h5, 4'hC, 4'h3};
  logic [3:0] seq3 [6] = '{4'h1, 4'h8, 4'h2, 4'h9, 4'h4, 4'hF};
  logic [3:0] seq4 [3] = '{4'h9, 4'h1, 4'h6};
  logic [3:0] seq5 [4] = '{4'h7, 4'h7, 4'h7, 4'h2};

  function automatic int su(int i); return (i == 0) ? S0 : S1; endfunction
  function automatic int gu(int i); return (i == 0) ? G0 : G1; endfunction
  function automatic int wn(int i); return (i == 0) ? S0 + G0 + H0 : S1 + G1 + H1; endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mhead[i] = 0; msize[i] = 0; mk[i] = 0; mact[i] = 0; msv[i] = 0;
        md[i] = '0; msh[i] = '0;
      end else begin
        m_push = vld && (msize[i] < DEPTH);
        m_may  = !mact[i];
        if (mact[i]) begin
          mk[i]++;
          if (mk[i] == wn(i)) begin
            msh[i] = md[i]; msv[i] = 1'b1; mact[i] = 1'b0; m_may = 1'b1;
          end
        end
        if (m_may && msize[i] > 0) begin
          m_w      = mbuf[i][mhead[i]];
          mhead[i] = (mhead[i] + 1) % 16;
          msize[i]--;
          if (!(COALESCE && msv[i] && m_w == msh[i])) begin
            md[i] = m_w; mact[i] = 1'b1; mk[i] = 0;
          end
        end
        if (m_push) begin
          mbuf[i][(mhead[i] + msize[i]) % 16] = data;
          msize[i]++;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_d", i), od[i], md[i]);
      chk($sformatf("u%0d_g", i), og[i], mact[i] && mk[i] >= su(i) && mk[i] < su(i) + gu(i));
      chk($sformatf("u%0d_count", i), ocnt[i], 8'(msize[i]));
      chk($sformatf("u%0d_ready", i), ordy[i], msize[i] < DEPTH);
      chk($sformatf("u%0d_busy", i), obusy[i], mact[i] || msize[i] != 0);
      chk($sformatf("u%0d_shadow", i), osh[i], msh[i]);
    end
  endtask

  task automatic monitor();
    for (int i = 0; i < 2; i++) begin
      if (og[i] === 1'b1 && gprev[i] !== 1'b1) begin
        gp[i]++;
        if (rn[i] < 64) rl[i][rn[i]] = od[i];
        rn[i]++;
      end
      if (og[i] === 1'b1 && gprev[i] === 1'b1 && od[i] !== dprev[i]) dchg[i]++;
      gprev[i] = og[i];
      dprev[i] = od[i];
    end
    if (int'(ocnt[1]) > peak1) peak1 = int'(ocnt[1]);
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 2; i++) begin
      gp[i] = 0; rn[i] = 0; dchg[i] = 0;
    end
    peak1 = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((obusy[0] !== 1'b0 || obusy[1] !== 1'b0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", {7'd0, obusy[0] | obusy[1]}, 8'd0);
    @(negedge clk);
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (chk_en) compare_all();
    monitor();
  end

  initial begin
    int n;
    rst = 1'b1; vld = 1'b0; data = '0; chk_en = 1'b0; total = 0; bad = 0;
    clear_mon();
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_d", od[0], 8'h0);
    chk("rst_g", og[0], 8'h0);
    chk("rst_count", ocnt[0], 8'h0);
    chk("rst_ready", ordy[0], 8'h1);
    chk("rst_busy", obusy[0], 8'h0);
    chk("rst_shadow", osh[0], 8'h0);
    rst = 1'b0;

    // Single word: latency of d, g window and shadow commit.
    data = 4'hA; vld = 1'b1;
    @(negedge clk); vld = 1'b0;
    @(negedge clk); chk("t1_d", od[0], 8'hA); chk("t1_g_setup", og[0], 8'h0);
    @(negedge clk); chk("t1_g_open1", og[0], 8'h1);
    @(negedge clk); chk("t1_g_open2", og[0], 8'h1);
    @(negedge clk); chk("t1_g_hold", og[0], 8'h0); chk("t1_shadow_early", osh[0], 8'h0);
    @(negedge clk); chk("t1_shadow", osh[0], 8'hA); chk("t1_busy", obusy[0], 8'h0);
    wait_idle();

    // Back-to-back words.
    clear_mon();
    for (int k = 0; k < 4; k++) begin
      data = seq2[k]; vld = 1'b1;
      chk("t2_ready", ordy[0], 8'h1);
      @(negedge clk);
    end
    vld = 1'b0;
    wait_idle();
    chk("t2_pulses", 8'(gp[0]), 8'd4);
    for (int k = 0; k < 4; k++) chk("t2_dseq", rl[0][k], seq2[k]);
    chk("t2_d_stable", 8'(dchg[0]), 8'd0);

    // Backpressure on the slow instance.
    clear_mon();
    vld = 1'b1;
    for (int k = 0; k < 6; k++) begin
      data = seq3[k];
      n = 0;
      while (ordy[1] !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("t3_ready_wait", ordy[1], 8'h1);
      @(negedge clk);
    end
    vld = 1'b0;
    wait_idle();
    chk("t3_peak", 8'(peak1), 8'd4);
    chk("t3_words", 8'(rn[1]), 8'd6);
    for (int k = 0; k < 6; k++) chk("t3_dseq", rl[1][k], seq3[k]);
    chk("t3_shadow", osh[1], seq3[5]);
    chk("t3_d_stable", 8'(dchg[1]), 8'd0);

    // Reset while the gate is open with two words queued.
    for (int k = 0; k < 3; k++) begin
      data = seq4[k]; vld = 1'b1;
      @(negedge clk);
    end
    vld = 1'b0;
    chk("t4_open_g", og[0], 8'h1);
    chk("t4_open_d", od[0], 8'h9);
    chk("t4_open_count", ocnt[0], 8'h2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_g", og[0], 8'h0);
    chk("t4_d", od[0], 8'h0);
    chk("t4_count", ocnt[0], 8'h0);
    chk("t4_shadow", osh[0], 8'h0);
    chk("t4_ready", ordy[0], 8'h1);
    chk("t4_count_u1", ocnt[1], 8'h0);
    clear_mon();
    repeat (12) @(negedge clk);
    chk("t4_no_pulse", 8'(rn[0]), 8'd0);
    chk("t4_d_after", od[0], 8'h0);

    // Repeated words.
    clear_mon();
    for (int k = 0; k < 4; k++) begin
      data = seq5[k]; vld = 1'b1;
      @(negedge clk);
    end
    vld = 1'b0;
    wait_idle();
    chk("t5_pulses_u0", 8'(gp[0]), COALESCE ? 8'd2 : 8'd4);
    chk("t5_pulses_u1", 8'(gp[1]), COALESCE ? 8'd2 : 8'd4);
    chk("t5_shadow_u0", osh[0], 8'h2);
    chk("t5_shadow_u1", osh[1], 8'h2);

    // Random traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      vld  = 1'($urandom_range(0, 1));
      data = (c % 2 == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      rst  = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    rst = 1'b0; vld = 1'b0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
